// File: rtl/puf_ro_cmp.sv
// RO PUF comparator: enables a pair of ring oscillators, waits for them to settle,
// counts synchronised rising edges of each over a programmable gate window, and
// reports the unsigned comparison as one response bit together with the raw counts.
module puf_ro_cmp #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win,
  input  logic             i_ro_a,
  input  logic             i_ro_b,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_resp,
  output logic             o_tie,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t             state;
  logic [SET_W-1:0]   set_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;
  logic [CNT_W-1:0]   cnt_a_nxt;
  logic [CNT_W-1:0]   cnt_b_nxt;

  // Synchroniser chain: p0/p1 resolve metastability, p2 holds the previous sample
  logic ro_a_p0, ro_a_p1, ro_a_p2;
  logic ro_b_p0, ro_b_p1, ro_b_p2;
  logic rise_a, rise_b;

  // Saturating increment: a counter parked at all-ones stays there
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX))
      return cnt + CNT_W'(1);
    else
      return cnt;
  endfunction

  // Bring both RO outputs into the clock domain; runs continuously so the chain is warm
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ro_a_p0 <= 1'b0;
      ro_a_p1 <= 1'b0;
      ro_a_p2 <= 1'b0;
      ro_b_p0 <= 1'b0;
      ro_b_p1 <= 1'b0;
      ro_b_p2 <= 1'b0;
    end else begin
      ro_a_p0 <= i_ro_a;
      ro_a_p1 <= ro_a_p0;
      ro_a_p2 <= ro_a_p1;
      ro_b_p0 <= i_ro_b;
      ro_b_p1 <= ro_b_p0;
      ro_b_p2 <= ro_b_p1;
    end
  end

  assign rise_a = ro_a_p1 & ~ro_a_p2;
  assign rise_b = ro_b_p1 & ~ro_b_p2;

  // Next counter values; only edges seen while in COUNT contribute
  always_comb begin
    cnt_a_nxt = sat_inc(cnt_a, rise_a && (state == ST_COUNT));
    cnt_b_nxt = sat_inc(cnt_b, rise_b && (state == ST_COUNT));
  end

  // Measurement sequencer with registered enable, status and result outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      set_cnt <= '0;
      win_cnt <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      o_en    <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_resp  <= 1'b0;
      o_tie   <= 1'b0;
      o_sat   <= 1'b0;
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            // A zero window would never terminate the countdown, so it becomes one cycle
            win_cnt <= (i_win == '0) ? WIN_W'(1) : i_win;
            set_cnt <= SET_LOAD;
            cnt_a   <= '0;
            cnt_b   <= '0;
            o_en    <= 1'b1;
            o_busy  <= 1'b1;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (set_cnt == SET_W'(1))
            state <= ST_COUNT;
          else
            set_cnt <= set_cnt - SET_W'(1);
        end
        ST_COUNT: begin
          cnt_a <= cnt_a_nxt;
          cnt_b <= cnt_b_nxt;
          if (win_cnt == WIN_W'(1)) begin
            // Results take the final-cycle increment directly so nothing is lost
            o_en    <= 1'b0;
            o_valid <= 1'b1;
            o_cnt_a <= cnt_a_nxt;
            o_cnt_b <= cnt_b_nxt;
            o_resp  <= (cnt_a_nxt > cnt_b_nxt);
            o_tie   <= (cnt_a_nxt == cnt_b_nxt);
            o_sat   <= (cnt_a_nxt == CNT_MAX) || (cnt_b_nxt == CNT_MAX);
            state   <= ST_DONE;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        ST_DONE: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_en   <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_ro_cmp.sv
// Bench for puf_ro_cmp: a 16-bit-counter instance and a 4-bit-counter instance share
// all inputs. Expected counts come from the recorded RO waveforms: a rising input
// transition is seen three clocks later, so it counts if it lands in the gate window.
module tb_puf_ro_cmp;
  localparam int S     = 4;
  localparam int WIN_W = 16;

  typedef struct {
    int w;
    int pa, pha, pb, phb;
    int exp_resp;   // -1 = don't care
    int exp_tie;
    int exp_sat1;   // small-counter instance
    int exp_ca1;
    int ca_lo, ca_hi, cb_lo, cb_hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, ro_a, ro_b;
  logic [WIN_W-1:0] win;

  logic en0, busy0, valid0, resp0, tie0, sat0;
  logic [15:0] ca0, cb0;
  logic en1, busy1, valid1, resp1, tie1, sat1;
  logic [3:0] ca1, cb1;

  int cyc;
  int n_chk, n_fail;
  int pa, pha, pb, phb;
  bit ha [0:65535];
  bit hb [0:65535];
  int m_a, m_b, m_a1, m_b1;
  bit have_prev;
  int prev_a, prev_b;

  puf_ro_cmp #(.CNT_W(16), .WIN_W(WIN_W), .SETTLE(S)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_win(win), .i_ro_a(ro_a), .i_ro_b(ro_b),
    .o_en(en0), .o_busy(busy0), .o_valid(valid0), .o_resp(resp0), .o_tie(tie0),
    .o_sat(sat0), .o_cnt_a(ca0), .o_cnt_b(cb0));

  puf_ro_cmp #(.CNT_W(4), .WIN_W(WIN_W), .SETTLE(S)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_win(win), .i_ro_a(ro_a), .i_ro_b(ro_b),
    .o_en(en1), .o_busy(busy1), .o_valid(valid1), .o_resp(resp1), .o_tie(tie1),
    .o_sat(sat1), .o_cnt_a(ca1), .o_cnt_b(cb1));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit wave(input int p, input int ph, input int c);
    if (p < 2) return 1'b0;
    return ((c + ph) % p) < (p / 2);
  endfunction

  // Advance one clock; new RO levels apply to (and are recorded for) the new cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ro_a = wave(pa, pha, cyc);
    ro_b = wave(pb, phb, cyc);
    ha[cyc] = ro_a;
    hb[cyc] = ro_b;
  endtask

  function automatic int model_cnt(input bit sel_b, input int t, input int w, input int width);
    int n, mx;
    bit cur, prv;
    n  = 0;
    mx = (1 << width) - 1;
    for (int c = t + S + 1; c <= t + S + w; c++) begin
      cur = sel_b ? hb[c-2] : ha[c-2];
      prv = sel_b ? hb[c-3] : ha[c-3];
      if (cur && !prv && n < mx) n++;
    end
    return n;
  endfunction

  // One measurement started in the current (idle) cycle; checks timing every cycle
  task automatic run_meas(input int w, input bit noise);
    int t, weff;
    t    = cyc;
    weff = (w == 0) ? 1 : w;
    win   = WIN_W'(w);
    start = 1'b1;
    for (int i = 1; i <= S + weff + 4; i++) begin
      step();
      start = noise && ((cyc == t + 2) || (cyc == t + S + 2));
      if (i == 1 && have_prev) begin
        check("hold_cnt_a", ca0, prev_a);
        check("hold_cnt_b", cb0, prev_b);
      end
      check("en",    en0,    (i >= 1) && (i <= S + weff));
      check("busy",  busy0,  (i >= 1) && (i <= S + weff + 1));
      check("valid", valid0, i == S + weff + 1);
      check("valid_s", valid1, i == S + weff + 1);
      if (i == S + weff + 1) begin
        m_a  = model_cnt(1'b0, t, weff, 16);
        m_b  = model_cnt(1'b1, t, weff, 16);
        m_a1 = model_cnt(1'b0, t, weff, 4);
        m_b1 = model_cnt(1'b1, t, weff, 4);
        check("cnt_a", ca0, m_a);
        check("cnt_b", cb0, m_b);
        check("resp",  resp0, m_a > m_b);
        check("tie",   tie0,  m_a == m_b);
        check("sat",   sat0,  (m_a == 65535) || (m_b == 65535));
        check("cnt_a_s", ca1, m_a1);
        check("cnt_b_s", cb1, m_b1);
        check("resp_s",  resp1, m_a1 > m_b1);
        check("tie_s",   tie1,  m_a1 == m_b1);
        check("sat_s",   sat1,  (m_a1 == 15) || (m_b1 == 15));
        prev_a = m_a;
        prev_b = m_b;
        have_prev = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int t, p, r;

    tbl[0] = '{120, 10, 0, 12, 0,  1,  0,  0, -1, 11, 12,  9, 10};
    tbl[1] = '{ 50, 10, 3, 10, 3,  0,  1,  0, -1, -1, -1, -1, -1};
    tbl[2] = '{120, 12, 0, 10, 0,  0,  0,  0, -1, -1, -1, -1, -1};
    tbl[3] = '{100,  4, 1,  0, 0,  1,  0,  1, 15, -1, -1, -1, -1};
    tbl[4] = '{  0,  3, 0,  5, 2, -1, -1, -1, -1, -1, -1, -1, -1};

    n_chk = 0; n_fail = 0; cyc = 0; have_prev = 1'b0;
    pa = 0; pha = 0; pb = 0; phb = 0;
    rst = 1'b0; start = 1'b0; win = '0; ro_a = 1'b0; ro_b = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_en",    en0, 0);
    check("rst_busy",  busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_cnt_a", ca0, 0);
    check("rst_resp",  resp0, 0);
    check("rst_sat",   sat0, 0);
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", valid0, 0);
      check("idle_en",    en0, 0);
      check("idle_busy",  busy0, 0);
      check("idle_cnt_a", ca0, 0);
    end

    // Directed table
    for (int k = 0; k < 5; k++) begin
      pa = tbl[k].pa; pha = tbl[k].pha; pb = tbl[k].pb; phb = tbl[k].phb;
      repeat (4) step();
      run_meas(tbl[k].w, 1'b0);
      if (tbl[k].exp_resp >= 0) begin
        check("tbl_resp", resp0, tbl[k].exp_resp);
        check("tbl_resp_s", resp1, tbl[k].exp_resp);
      end
      if (tbl[k].exp_tie >= 0) check("tbl_tie", tie0, tbl[k].exp_tie);
      if (tbl[k].exp_sat1 >= 0) check("tbl_sat_s", sat1, tbl[k].exp_sat1);
      if (tbl[k].exp_ca1 >= 0) begin
        check("tbl_cnt_a_s", ca1, tbl[k].exp_ca1);
        check("tbl_cnt_b_s", cb1, 0);
      end
      if (tbl[k].ca_lo >= 0) begin
        check("tbl_cnt_a_range", (ca0 >= tbl[k].ca_lo) && (ca0 <= tbl[k].ca_hi), 1);
        check("tbl_cnt_b_range", (cb0 >= tbl[k].cb_lo) && (cb0 <= tbl[k].cb_hi), 1);
      end
    end

    // Extra start pulses during SETTLE and COUNT must be ignored
    pa = 7; pha = 2; pb = 9; phb = 5;
    repeat (2) step();
    run_meas(50, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("noise_no_valid", valid0, 0);
      check("noise_idle_busy", busy0, 0);
    end

    // Start held high: back-to-back measurements with a fixed period
    pa = 6; pha = 0; pb = 8; phb = 1;
    step();
    t = cyc;
    p = S + 10 + 2;
    win = WIN_W'(10);
    start = 1'b1;
    for (int i = 1; i <= 3 * p - 1; i++) begin
      step();
      r = (cyc - t) % p;
      check("held_en",    en0,    (r >= 1) && (r <= S + 10));
      check("held_busy",  busy0,  (r >= 1) && (r <= S + 11));
      check("held_valid", valid0, r == S + 11);
    end
    start = 1'b0;
    step();
    have_prev = 1'b0;

    // Randomised measurements against the waveform model
    for (int k = 0; k < 8; k++) begin
      pa = $urandom_range(0, 16); pha = $urandom_range(0, 15);
      pb = $urandom_range(0, 16); phb = $urandom_range(0, 15);
      repeat ($urandom_range(1, 4)) step();
      run_meas($urandom_range(0, 40), 1'b0);
    end

    // Reset during COUNT aborts at once, then a fresh measurement works
    pa = 10; pha = 0; pb = 12; phb = 0;
    repeat (3) step();
    win = WIN_W'(120);
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
    while (cyc < t + S + 5) step();
    #2 rst = 1'b1;
    #1;
    check("abort_en",    en0, 0);
    check("abort_busy",  busy0, 0);
    check("abort_valid", valid0, 0);
    check("abort_cnt_a", ca0, 0);
    check("abort_cnt_b", cb0, 0);
    check("abort_resp",  resp0, 0);
    check("abort_sat",   sat0, 0);
    check("abort_en_s",  en1, 0);
    repeat (2) step();
    rst = 1'b0;
    have_prev = 1'b0;
    repeat (3) step();
    run_meas(120, 1'b0);
    check("post_rst_resp", resp0, 1);
    check("post_rst_tie",  tie0, 0);
    check("post_rst_sat",  sat0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
